serial_compare_arbiter: RTL and testbench
=========================================

SERIAL_COMPARE_ARBITER -- requirements
Module: serial_compare_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports req0_valid, req1_valid  input  1  requester N has an operand pair to compare.
REQ-005 The block SHALL have ports req0_ready, req1_ready  output  1  block accepts requester N's pair this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  unsigned operands of requester N.
REQ-007 The block SHALL have port ser_valid  output  1  a serial bit pair is being compared this cycle.
REQ-008 The block SHALL have ports ser_a, ser_b  output  1  current serial operand bits, MSB first.
REQ-009 The block SHALL have port res_valid  output  1  a comparison result is held.
REQ-010 The block SHALL have port res_ready  input  1  consumer takes the result.
REQ-011 The block SHALL have port res_id  output  1  requester index the result belongs to.
REQ-012 The block SHALL have ports res_less, res_eq, res_greater  output  1  a<b, a==b, a>b; exactly one set when res_valid=1.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT, DONE; transitions IDLE->SHIFT on request handshake, SHIFT->DONE after WIDTH SHIFT cycles, DONE->IDLE on res_valid&res_ready.
REQ-014 reqN_ready SHALL be 1 only in IDLE, only for the selected requester, and only when that requester's valid is 1; the other ready SHALL be 0.
REQ-015 Selection SHALL be round-robin: one valid -> that requester; both valid -> the requester not granted last; pointer updates only on an accepted handshake.
REQ-016 On accept, the block SHALL latch the selected a, b and requester index, clear the internal comparator state to prev_eq=1, prev_greater=0, and load bit index WIDTH-1.
REQ-017 In SHIFT, ser_valid SHALL be 1 and ser_a/ser_b SHALL present latched bits [idx], idx decrementing WIDTH-1 down to 0, one bit per cycle.
REQ-018 Per SHIFT cycle: eq = prev_eq & (a_bit==b_bit); greater = prev_greater | (prev_eq & a_bit & ~b_bit); less = ~eq & ~greater; prev_* SHALL register eq/greater.
REQ-019 On the edge ending the last SHIFT cycle (idx=0), the block SHALL register res_less/res_eq/res_greater and res_id, and assert res_valid the following cycle; latency from accept edge to res_valid=1 SHALL be exactly WIDTH cycles.
REQ-020 The block SHALL hold res_* stable in DONE while res_ready=0; with res_ready=1 it SHALL return to IDLE on that edge, and a new request SHALL be acceptable in the next cycle.
REQ-021 Operand or valid changes during SHIFT/DONE SHALL NOT affect the comparison in progress.
REQ-022 Outside SHIFT, ser_valid, ser_a and ser_b SHALL be 0; outside DONE, res_valid SHALL be 0 and res_less/res_eq/res_greater SHALL hold their last values.
REQ-023 WIDTH=1 SHALL produce a single SHIFT cycle with the same rules.

Reset
REQ-024 While rst=1: state=IDLE, req0_ready=req1_ready=0, ser_valid=ser_a=ser_b=0, res_valid=0, res_id=0, res_less=0, res_eq=1, res_greater=0, round-robin pointer set so req0 wins the first tie.
REQ-025 rst asserted in SHIFT or DONE SHALL abandon the operation with no result delivered; rst takes priority over every handshake in the same cycle.

Verification
REQ-026 WIDTH=8, req0 a=0x5A b=0x5A, res_ready=1 -> res_valid 8 cycles after accept, res_eq=1, res_id=0.
REQ-027 req0 a=0x80 b=0x7F -> res_greater=1 (decided on MSB); req1 a=0x10 b=0x11 -> res_less=1 (decided on LSB), res_id=1; ser_a sequence for 0x80 = 1,0,0,0,0,0,0,0.
REQ-028 Both valid continuously, ops 0x01 vs 0x02 -> grants alternate req0, req1, req0, req1; never two consecutive same-id results.
REQ-029 res_ready=0 for 5 cycles after res_valid -> results and res_id stable, both readies 0, then one handshake and return to IDLE.
REQ-030 rst pulsed at 4th SHIFT cycle -> no res_valid, reset values per REQ-024, next request completes normally with the correct result.

Source files
------------

// File: rtl/serial_compare_arbiter.sv
// rtl/serial_compare_arbiter.sv - two-requester round-robin arbiter feeding an MSB-first bit-serial magnitude comparator
module serial_compare_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_less,
  output logic             res_eq,
  output logic             res_greater
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] a_shr, b_shr;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             id_q, id_d;
  logic             prev_eq_q, prev_eq_d;
  logic             prev_gt_q, prev_gt_d;
  logic             last_q, last_d;
  logic             res_id_q, res_id_d;
  logic             res_less_q, res_less_d;
  logic             res_eq_q, res_eq_d;
  logic             res_gt_q, res_gt_d;
  logic             sel, grant, bit_a, bit_b, eq_n, gt_n;

  // Pick a requester: a lone valid wins, a tie goes to the one not granted last
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_q;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  // Only an idle, non-reset block offers a handshake, and only to the selected side
  assign grant      = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = grant && !sel;
  assign req1_ready = grant && sel;

  // Shift-then-take-LSB keeps the bit select legal for every WIDTH, including 1
  assign a_shr = a_q >> idx_q;
  assign b_shr = b_q >> idx_q;
  assign bit_a = a_shr[0];
  assign bit_b = b_shr[0];
  assign eq_n  = prev_eq_q & (bit_a == bit_b);
  assign gt_n  = prev_gt_q | (prev_eq_q & bit_a & ~bit_b);

  // Next-state, operand capture, per-bit compare step and result capture
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    id_d       = id_q;
    prev_eq_d  = prev_eq_q;
    prev_gt_d  = prev_gt_q;
    last_d     = last_q;
    res_id_d   = res_id_q;
    res_less_d = res_less_q;
    res_eq_d   = res_eq_q;
    res_gt_d   = res_gt_q;
    ser_valid  = 1'b0;
    ser_a      = 1'b0;
    ser_b      = 1'b0;
    res_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = SHIFT;
          a_d       = sel ? req1_a : req0_a;
          b_d       = sel ? req1_b : req0_b;
          id_d      = sel;
          last_d    = sel;
          prev_eq_d = 1'b1;
          prev_gt_d = 1'b0;
          idx_d     = IDXW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        ser_valid = !rst;
        ser_a     = bit_a & !rst;
        ser_b     = bit_b & !rst;
        prev_eq_d = eq_n;
        prev_gt_d = gt_n;
        if (idx_q == '0) begin
          state_d    = DONE;
          res_id_d   = id_q;
          res_less_d = ~eq_n & ~gt_n;
          res_eq_d   = eq_n;
          res_gt_d   = gt_n;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      DONE: begin
        res_valid = !rst;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register update; reset abandons any operation and leaves req0 winning the next tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      id_q       <= 1'b0;
      prev_eq_q  <= 1'b1;
      prev_gt_q  <= 1'b0;
      last_q     <= 1'b1;
      res_id_q   <= 1'b0;
      res_less_q <= 1'b0;
      res_eq_q   <= 1'b1;
      res_gt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      id_q       <= id_d;
      prev_eq_q  <= prev_eq_d;
      prev_gt_q  <= prev_gt_d;
      last_q     <= last_d;
      res_id_q   <= res_id_d;
      res_less_q <= res_less_d;
      res_eq_q   <= res_eq_d;
      res_gt_q   <= res_gt_d;
    end
  end

  assign res_id      = res_id_q;
  assign res_less    = res_less_q;
  assign res_eq      = res_eq_q;
  assign res_greater = res_gt_q;

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// tb/tb_serial_compare_arbiter.sv - scoreboard bench for serial_compare_arbiter
module tb_serial_compare_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b1, req1_valid = 1'b1;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         res_ready = 1'b0;
  logic         req0_ready, req1_ready, ser_valid, ser_a, ser_b;
  logic         res_valid, res_id, res_less, res_eq, res_greater;

  logic         s_valid = 1'b0;
  logic [0:0]   s_a = '0, s_b = '0;
  logic         s_ready0, s_ready1, s_ser_valid, s_ser_a, s_ser_b;
  logic         s_res_valid, s_res_id, s_less, s_eq, s_gt;

  typedef struct {
    bit id;
    bit less;
    bit eq;
    bit gt;
    int acc;
  } exp_t;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  bit           mdl_last = 1'b1;
  logic [W-1:0] sh_a = '0, sh_b = '0;
  int           sh_k = 0;
  int           rr_mode = 0;
  bit           alt_chk = 1'b0;
  bit           have_last = 1'b0;
  bit           last_pop_id = 1'b0;

  serial_compare_arbiter #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .ser_valid(ser_valid), .ser_a(ser_a), .ser_b(ser_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater)
  );

  serial_compare_arbiter #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .req0_valid(s_valid), .req1_valid(1'b0),
    .req0_ready(s_ready0), .req1_ready(s_ready1),
    .req0_a(s_a), .req0_b(s_b), .req1_a(1'b0), .req1_b(1'b0),
    .ser_valid(s_ser_valid), .ser_a(s_ser_a), .ser_b(s_ser_b),
    .res_valid(s_res_valid), .res_ready(1'b1), .res_id(s_res_id),
    .res_less(s_less), .res_eq(s_eq), .res_greater(s_gt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used for latency checks
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic gen_ops(output logic [W-1:0] a, output logic [W-1:0] b);
    a = W'($urandom);
    b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
  endtask

  // Present a request, wait for the handshake, predict the grant and push the expected result
  task automatic do_txn(input bit v0, input bit v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input bit rerand, input bit hold);
    bit           got = 1'b0;
    bit           pred;
    exp_t         e;
    logic [W-1:0] a, b;
    for (int t = 0; t < 80 && !got; t++) begin
      @(negedge clk);
      if (t > 0 && rerand) begin
        v0 = 1'($urandom);
        v1 = 1'($urandom);
        if (!v0 && !v1) v0 = 1'b1;
        gen_ops(a0, b0);
        gen_ops(a1, b1);
      end
      req0_valid = v0; req1_valid = v1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      #1;
      if (req0_ready || req1_ready) begin
        got  = 1'b1;
        pred = (v0 && v1) ? ~mdl_last : v1;
        chk("grant", {req1_ready, req0_ready}, pred ? 2'b10 : 2'b01);
        mdl_last = pred;
        a = pred ? a1 : a0;
        b = pred ? b1 : b0;
        e.id = pred; e.less = (a < b); e.eq = (a == b); e.gt = (a > b); e.acc = cyc + 1;
        exp_q.push_back(e);
        sh_a = a; sh_b = b; sh_k = 0;
      end
    end
    chk("handshake_timeout", got, 1);
    @(negedge clk);
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Serial stream monitor: each shifted bit must be the next MSB-first bit of the accepted pair
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (ser_valid) begin
        chk("ser_ready_low", {req1_ready, req0_ready}, 0);
        chk("ser_in_range", sh_k < W, 1);
        if (sh_k < W) begin
          chk("ser_a", ser_a, sh_a[W-1-sh_k]);
          chk("ser_b", ser_b, sh_b[W-1-sh_k]);
        end
        sh_k++;
      end else begin
        chk("ser_idle_zero", {ser_a, ser_b}, 0);
      end
    end
  end

  // Result monitor: drives res_ready, checks latency, hold stability, then pops and compares
  bit         prev_valid = 1'b0;
  int         hold_cnt = 0;
  logic [3:0] prev_res = '0;
  always @(negedge clk) begin
    exp_t e;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = ($urandom_range(0, 3) != 0);
      default: res_ready = (hold_cnt >= 5);
    endcase
    #1;
    if (rst) begin
      prev_valid = 1'b0;
      hold_cnt   = 0;
    end else if (res_valid) begin
      chk("done_ready_low", {req1_ready, req0_ready}, 0);
      chk("onehot", $countones({res_less, res_eq, res_greater}), 1);
      if (!prev_valid) begin
        chk("unexpected_result", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("latency", cyc - exp_q[0].acc, W);
          chk("ser_bits", sh_k, W);
        end
      end else begin
        chk("hold_stable", {res_id, res_less, res_eq, res_greater}, prev_res);
      end
      if (res_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_cmp", {res_less, res_eq, res_greater}, {e.less, e.eq, e.gt});
          if (alt_chk && have_last) chk("alternate", res_id != last_pop_id, 1);
          last_pop_id = res_id;
          have_last   = 1'b1;
        end
        prev_valid = 1'b0;
        hold_cnt   = 0;
      end else begin
        prev_valid = 1'b1;
        prev_res   = {res_id, res_less, res_eq, res_greater};
        hold_cnt++;
      end
    end
  end

  // Watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Directed and random stimulus sequence
  initial begin
    exp_t         e;
    bit           v0, v1;
    logic [W-1:0] a0, b0, a1, b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_ser", {ser_valid, ser_a, ser_b}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", {res_id, res_less, res_eq, res_greater}, 4'b0010);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_a = 1'(i >> 1); s_b = 1'(i); s_valid = 1'b1;
      #1;
      chk("w1_ready", {s_ready1, s_ready0}, 2'b01);
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      chk("w1_ser", {s_ser_valid, s_ser_a, s_ser_b}, {1'b1, s_a, s_b});
      @(negedge clk);
      #1;
      chk("w1_res", {s_res_valid, s_res_id, s_less, s_eq, s_gt},
          {1'b1, 1'b0, s_a < s_b, s_a == s_b, s_a > s_b});
    end

    rr_mode = 0;
    do_txn(1, 0, 8'h5A, 8'h5A, 8'h00, 8'h00, 0, 0);
    do_txn(1, 0, 8'h80, 8'h7F, 8'hFF, 8'h00, 0, 0);
    do_txn(0, 1, 8'h00, 8'hFF, 8'h10, 8'h11, 0, 0);
    drain();

    alt_chk = 1'b1; have_last = 1'b0;
    for (int i = 0; i < 6; i++) do_txn(1, 1, 8'h01, 8'h02, 8'h01, 8'h02, 0, i < 5);
    drain();
    alt_chk = 1'b0;

    rr_mode = 2;
    do_txn(1, 1, 8'h33, 8'h44, 8'hC0, 8'h0C, 0, 0);
    drain();
    rr_mode = 0;

    do_txn(1, 0, 8'hF0, 8'h0F, 8'h00, 8'h00, 0, 0);
    e = exp_q.pop_back();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {req1_ready, req0_ready}, 0);
    chk("mid_rst_ser", {ser_valid, ser_a, ser_b}, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    mdl_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_res", {res_valid, res_id, res_less, res_eq, res_greater}, 5'b00010);
    repeat (12) @(negedge clk);
    do_txn(1, 1, 8'h22, 8'h21, 8'h00, 8'hFF, 0, 0);
    drain();

    rr_mode = 1;
    for (int i = 0; i < 60; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v1 = 1'b1;
      gen_ops(a0, b0);
      gen_ops(a1, b1);
      do_txn(v0, v1, a0, b0, a1, b1, 1, (i < 59) && 1'($urandom));
    end
    drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
